step_pattern_gen: RTL
=====================

STEP_PATTERN_GEN -- requirements
Module: step_pattern_gen

Interface
REQ-001 Param SHOW_TICKS, 4, tick pulses the target pattern is displayed per round (>=1).
REQ-002 Param PLAY_TICKS, 16, tick pulses the player has to respond per round (>=8).
REQ-003 Param LFSR_SEED, 8'hA5, LFSR reset value (nonzero).
REQ-004 One clock; reset is asynchronous and active-high: clk input 1, system clock; rst input 1, async active-high reset.
REQ-005 tick input 1: single-cycle time-base enable pulse.
REQ-006 start input 1: level/pulse; begins a game when idle.
REQ-007 btn input 4: synchronized, debounced step buttons; nonzero = press.
REQ-008 pattern output 4: target step, one-hot; feeds downstream 2:1 nibble mux A.
REQ-009 player output 4: captured player step; feeds mux B.
REQ-010 sel output 1: mux select; 0 = show pattern, 1 = show player.
REQ-011 hit, miss outputs 1 each: single-cycle round-result pulses.
REQ-012 score output 8: rounds won this game; busy output 1: game in progress.

Function
REQ-013 FSM states IDLE, SHOW, PLAY, JUDGE; all outputs registered.
REQ-014 8-bit LFSR, taps x^8+x^6+x^5+x^4+1, advances every clk cycle regardless of state; never reaches 0.
REQ-015 IDLE: busy=0, sel=0; start=1 -> SHOW next cycle, score cleared to 0, player cleared to 0.
REQ-016 Entering SHOW: pattern = 4'b0001 << lfsr[1:0] sampled at the transition edge, tick counter cleared, sel=0, busy=1.
REQ-017 SHOW -> PLAY on the cycle after the SHOW_TICKS-th tick pulse; btn ignored in SHOW.
REQ-018 Entering PLAY: sel=1, player=0, tick counter cleared.
REQ-019 PLAY: first cycle with btn!=0 -> player<=btn, go JUDGE; else the cycle after the window-th tick -> player stays 0, go JUDGE.
REQ-020 btn!=0 and final tick in the same cycle: button press wins (captured).
REQ-021 JUDGE (exactly 1 cycle): player==pattern -> hit=1, score+1 saturating at 255, then SHOW; else miss=1, then IDLE.
REQ-022 Multi-bit btn capture never equals one-hot pattern -> miss.
REQ-023 hit/miss asserted only in the cycle after JUDGE entry, never both; 0 otherwise.
REQ-024 start while busy=1 is ignored.
REQ-025 pattern and player hold their last values in IDLE until next game start (for display).
REQ-026 Round latency: start -> first sel=1 is 1 + SHOW_TICKS tick periods (+1 cycle).

Reset
REQ-027 rst=1 forces, without waiting for clk: state IDLE, lfsr=LFSR_SEED, pattern=0, player=0, sel=0, hit=0, miss=0, score=0, busy=0, counters 0.
REQ-028 rst mid-round aborts immediately; no hit/miss pulse is produced; after release, block waits in IDLE for start.

Configuration
REQ-029 Macro STEP_SPEEDUP_EN defined: play window = PLAY_TICKS - (PLAY_TICKS>>3)*min(score,6), floor PLAY_TICKS>>2 ticks, recomputed at PLAY entry.
REQ-030 Macro STEP_SPEEDUP_EN undefined: play window fixed at PLAY_TICKS; no speedup logic synthesized.

Verification (SHOW_TICKS=4, PLAY_TICKS=16, tick every 4 clk)
REQ-031 rst pulse mid-PLAY with score=3 -> same cycle score=0, sel=0, busy=0, state IDLE; no hit/miss.
REQ-032 start, after 4 ticks press btn=pattern -> player=pattern, one hit pulse, score=1, SHOW reentered with new LFSR-derived pattern.
REQ-033 start, press btn=4'b0011 in PLAY -> player=4'b0011, miss pulse, busy=0, score=0.
REQ-034 start, no press -> after 16 ticks player=0, miss, IDLE; press on 16th-tick cycle -> captured, judged normally.
REQ-035 force score 255 path (256 hits) -> score stays 255, hit still pulses; start pulses during busy have no effect.
REQ-036 STEP_SPEEDUP_EN: after 6 hits window = 16-2*6=4 ticks; no-press miss occurs after exactly 4 ticks; undefined -> 16 ticks.

Source files
------------

// File: rtl/step_pattern_gen.sv
// Step-pattern memory game: shows a one-hot target, captures the player's button press, judges and scores.
// Optional macro STEP_SPEEDUP_EN shortens the play window as the score rises.
module step_pattern_gen #(
  parameter int unsigned SHOW_TICKS = 4,
  parameter int unsigned PLAY_TICKS = 16,
  parameter logic [7:0]  LFSR_SEED  = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       start,
  input  logic [3:0] btn,
  output logic [3:0] pattern,
  output logic [3:0] player,
  output logic       sel,
  output logic       hit,
  output logic       miss,
  output logic [7:0] score,
  output logic       busy
);

  localparam int unsigned MAXT = (SHOW_TICKS > PLAY_TICKS) ? SHOW_TICKS : PLAY_TICKS;
  localparam int unsigned CW   = $clog2(MAXT + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHOW  = 2'd1;
  localparam logic [1:0] S_PLAY  = 2'd2;
  localparam logic [1:0] S_JUDGE = 2'd3;

  logic [1:0]    state, state_d;
  logic [7:0]    lfsr, lfsr_d;
  logic [CW-1:0] tcnt, tcnt_d;
  logic [3:0]    pattern_d, player_d;
  logic          sel_d, hit_d, miss_d, busy_d;
  logic [7:0]    score_d;
  logic [3:0]    onehot_c;
  logic          show_last_c, play_last_c;

`ifdef STEP_SPEEDUP_EN
  // Window shrinks by PLAY_TICKS/8 per won round (up to 6), floored at PLAY_TICKS/4.
  logic [CW-1:0] win, win_d, win_next_c, dec_c, raw_c;
  logic [2:0]    sc6_c;

  always_comb begin
    sc6_c      = (score > 8'd6) ? 3'd6 : score[2:0];
    dec_c      = CW'(PLAY_TICKS >> 3) * CW'(sc6_c);
    raw_c      = CW'(PLAY_TICKS) - dec_c;
    win_next_c = (raw_c < CW'(PLAY_TICKS >> 2)) ? CW'(PLAY_TICKS >> 2) : raw_c;
    play_last_c = (tcnt == win - CW'(1));
  end
`else
  always_comb play_last_c = (tcnt == CW'(PLAY_TICKS - 1));
`endif

  assign onehot_c    = 4'b0001 << lfsr[1:0];
  assign show_last_c = (tcnt == CW'(SHOW_TICKS - 1));

  // Next-state and next-output logic
  always_comb begin
    state_d   = state;
    lfsr_d    = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    tcnt_d    = tcnt;
    pattern_d = pattern;
    player_d  = player;
    sel_d     = sel;
    busy_d    = busy;
    score_d   = score;
    hit_d     = 1'b0;
    miss_d    = 1'b0;
`ifdef STEP_SPEEDUP_EN
    win_d     = win;
`endif
    case (state)
      S_IDLE: begin
        busy_d = 1'b0;
        sel_d  = 1'b0;
        if (start) begin
          state_d   = S_SHOW;
          score_d   = 8'd0;
          player_d  = 4'd0;
          pattern_d = onehot_c;
          tcnt_d    = '0;
          busy_d    = 1'b1;
        end
      end
      S_SHOW: begin
        if (tick) begin
          if (show_last_c) begin
            state_d  = S_PLAY;
            sel_d    = 1'b1;
            player_d = 4'd0;
            tcnt_d   = '0;
`ifdef STEP_SPEEDUP_EN
            win_d    = win_next_c;
`endif
          end else begin
            tcnt_d = tcnt + CW'(1);
          end
        end
      end
      S_PLAY: begin
        // A press beats a coincident final tick
        if (btn != 4'd0) begin
          player_d = btn;
          state_d  = S_JUDGE;
        end else if (tick) begin
          if (play_last_c) state_d = S_JUDGE;
          else             tcnt_d  = tcnt + CW'(1);
        end
      end
      S_JUDGE: begin
        sel_d = 1'b0;
        if (player == pattern) begin
          hit_d     = 1'b1;
          score_d   = (score == 8'hFF) ? score : score + 8'd1;
          state_d   = S_SHOW;
          pattern_d = onehot_c;
          tcnt_d    = '0;
        end else begin
          miss_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      lfsr    <= LFSR_SEED;
      tcnt    <= '0;
      pattern <= 4'd0;
      player  <= 4'd0;
      sel     <= 1'b0;
      hit     <= 1'b0;
      miss    <= 1'b0;
      score   <= 8'd0;
      busy    <= 1'b0;
`ifdef STEP_SPEEDUP_EN
      win     <= '0;
`endif
    end else begin
      state   <= state_d;
      lfsr    <= lfsr_d;
      tcnt    <= tcnt_d;
      pattern <= pattern_d;
      player  <= player_d;
      sel     <= sel_d;
      hit     <= hit_d;
      miss    <= miss_d;
      score   <= score_d;
      busy    <= busy_d;
`ifdef STEP_SPEEDUP_EN
      win     <= win_d;
`endif
    end
  end

endmodule
